// File: rtl/mem_byte_responder.sv
// Byte-wide memory responder: word/byte reads and writes over a single
// request/response handshake, moving one byte of storage per clock.
module mem_byte_responder #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] DEPTH_X = 33'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_ERR,
    S_RESP
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      k, k_nx;
  logic            cap_write;
  logic            cap_byte;
  logic [AW-1:0]   cap_addr;
  logic [31:0]     cap_wdata;
  logic [31:0]     asm_q, asm_nx;
  logic [7:0]      mem [DEPTH];

  logic            accept;
  logic            req_err;
  logic            last_beat;
  logic [32:0]     addr_x;
  logic [AW-1:0]   beat_addr;
  logic [7:0]      rd_byte;
  logic [7:0]      wr_byte;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // 33-bit compare so word addresses near 2^32 cannot wrap past the bound.
  assign addr_x  = {1'b0, req_addr};
  assign req_err = (addr_x >= DEPTH_X) ||
                   (!req_byte && ((req_addr[1:0] != 2'b00) ||
                                  (addr_x + 33'd3 >= DEPTH_X)));

  assign beat_addr = cap_addr + AW'(k);
  assign rd_byte   = mem[beat_addr];
  assign wr_byte   = cap_wdata[{k, 3'b000} +: 8];
  assign last_beat = cap_byte || (k == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  // Rejected requests idle one cycle in S_ERR so their response lands at the
  // same edge a byte access would, keeping error and byte timing identical.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    asm_nx   = asm_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = req_err ? S_ERR : S_BEAT;
          k_nx     = '0;
        end
      end
      S_BEAT: begin
        if (!cap_write) asm_nx[{k, 3'b000} +: 8] = rd_byte;
        if (last_beat) begin
          state_nx = S_RESP;
          k_nx     = '0;
        end else begin
          k_nx = k + 2'd1;
        end
      end
      S_ERR:   state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_write <= 1'b0;
      cap_byte  <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      asm_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_byte  <= req_byte;
        cap_addr  <= req_addr[AW-1:0];
        cap_wdata <= req_wdata;
        asm_q     <= '0;
      end
      if (state == S_BEAT) begin
        asm_q <= asm_nx;
        if (last_beat) begin
          rsp_rdata <= cap_write ? '0 : asm_nx;
          rsp_err   <= 1'b0;
        end
      end
      if (state == S_ERR) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if ((state == S_BEAT) && cap_write) mem[beat_addr] <= wr_byte;
  end

endmodule

// File: tb/tb_mem_byte_responder.sv
// Scoreboard bench for mem_byte_responder: directed requests push expected
// responses; a negedge monitor pops and compares data, error flag and latency.
module tb_mem_byte_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
    int unsigned lat;
    string       name;
  } exp_t;

  exp_t q[$];

  mem_byte_responder #(.DEPTH(256)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid with no request outstanding at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
        chk({e.name, "_latency"}, cyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic issue(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
    req_write = w;
    req_byte  = b;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
  endtask

  task automatic push(input logic [31:0] er, input logic ee, input int unsigned lat, input string nm);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    e.acc   = cyc;
    e.lat   = lat;
    e.name  = nm;
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic do_req(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input int unsigned lat,
                        input string nm);
    issue(w, b, a, d);
    wait_ready();
    @(posedge clk);
    #1;
    push(er, ee, lat, nm);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
    req_addr  = 32'hFFFF_FFFF;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
    chk({nm, "_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({nm, "_rdata"}, rsp_rdata, 32'd0);
    chk({nm, "_err"}, {31'b0, rsp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int low;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Word write then read-back, plus a byte out of the middle of it.
    do_req(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 4, "wr_w10");
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 4, "rd_w10");
    do_req(1'b0, 1'b1, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 1, "rd_b13");

    // Vector bytes are ordinary storage.
    do_req(1'b1, 1'b1, 32'd253, 32'hFFFF_FF11, 32'h0, 1'b0, 1, "wr_b253");
    do_req(1'b1, 1'b1, 32'd254, 32'h0000_0022, 32'h0, 1'b0, 1, "wr_b254");
    do_req(1'b1, 1'b1, 32'd255, 32'h1234_5633, 32'h0, 1'b0, 1, "wr_b255");
    do_req(1'b1, 1'b1, 32'd252, 32'h0000_0044, 32'h0, 1'b0, 1, "wr_b252");
    do_req(1'b0, 1'b1, 32'd253, 32'h0, 32'h0000_0011, 1'b0, 1, "rd_b253");
    do_req(1'b0, 1'b1, 32'd254, 32'h0, 32'h0000_0022, 1'b0, 1, "rd_b254");
    do_req(1'b0, 1'b1, 32'd255, 32'h0, 32'h0000_0033, 1'b0, 1, "rd_b255");
    do_req(1'b0, 1'b0, 32'd252, 32'h0, 32'h3322_1144, 1'b0, 4, "rd_w252");

    // Rejected accesses: misaligned, past the end, and wrap-around.
    do_req(1'b0, 1'b0, 32'd253, 32'h0, 32'h0, 1'b1, 1, "err_rd_w253");
    do_req(1'b1, 1'b0, 32'd254, 32'h0BAD_0BAD, 32'h0, 1'b1, 1, "err_wr_w254");
    do_req(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1, "err_rd_wtop");
    do_req(1'b1, 1'b1, 32'd0, 32'h0000_005A, 32'h0, 1'b0, 1, "wr_b0");
    do_req(1'b1, 1'b1, 32'd256, 32'h0000_0077, 32'h0, 1'b1, 1, "err_wr_b256");
    do_req(1'b0, 1'b1, 32'd0, 32'h0, 32'h0000_005A, 1'b0, 1, "rd_b0_after_err");
    do_req(1'b0, 1'b1, 32'd253, 32'h0, 32'h0000_0011, 1'b0, 1, "rd_b253_after_err");

    // Asynchronous reset mid-cycle clears the response registers at once.
    drain();
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset after two completed beats of a word write: no response, partial bytes kept.
    do_req(1'b1, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 4, "wr_w20");
    drain();
    issue(1'b1, 1'b0, 32'h20, 32'hAABB_CCDD);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("abort_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 32'h1122_CCDD, 1'b0, 4, "rd_w20_after_abort");
    drain();

    // Back-to-back word reads with req_valid held high.
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, (i % 2 == 1) ? 32'h20 : 32'h10, 32'h0);
      wait_ready();
      @(posedge clk);
      #1;
      push((i % 2 == 1) ? 32'h1122_CCDD : 32'hDEAD_BEEF, 1'b0, 4, "b2b_rd");
      @(negedge clk);
      low = 0;
      while (!req_ready && low < 20) begin
        low++;
        @(negedge clk);
      end
      chk("b2b_ready_low_cycles", low, 32'd5);
    end
    req_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    chk("final_queue_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
